// File: rtl/mdr_mem_sequencer.sv
// Sequences MAR/MDR/memory strobes for one read or write transaction per start request,
// waiting on mem_ready with a bounded timeout.
//
// state      | meaning
// -----------+-----------------------------------------------
// S_IDLE     | waiting for start; rw latched into op on accept
// S_LOAD_MAR | MAR captures the address from the bus
// S_LOAD_MDR | write only: MDR captures write data from the bus
// S_MEM_REQ  | memory access in flight, waiting for mem_ready
// S_CAPTURE  | read only: MDR captures chip data
// S_DRIVE    | read only: MDR drives the bus
// S_DONE     | completion pulse
// S_ERR      | completion pulse with timeout error
module mdr_mem_sequencer #(
   parameter int TIMEOUT = 8
) (
   input  logic clock,
   input  logic clear,
   input  logic start,
   input  logic rw,
   input  logic mem_ready,
   output logic MARin,
   output logic MDRin,
   output logic read,
   output logic MDRout,
   output logic mem_en,
   output logic mem_wr,
   output logic busy,
   output logic done,
   output logic error
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_MAR,
      S_LOAD_MDR,
      S_MEM_REQ,
      S_CAPTURE,
      S_DRIVE,
      S_DONE,
      S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic            op_q, op_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      MARin   = 1'b0;
      MDRin   = 1'b0;
      read    = 1'b0;
      MDRout  = 1'b0;
      mem_en  = 1'b0;
      mem_wr  = 1'b0;
      done    = 1'b0;
      error   = 1'b0;
      busy    = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = rw;
               state_d = S_LOAD_MAR;
            end
         end
         S_LOAD_MAR: begin
            MARin   = 1'b1;
            cnt_d   = '0;
            state_d = op_q ? S_LOAD_MDR : S_MEM_REQ;
         end
         S_LOAD_MDR: begin
            MDRin   = 1'b1;
            cnt_d   = '0;
            state_d = S_MEM_REQ;
         end
         S_MEM_REQ: begin
            mem_en = 1'b1;
            mem_wr = op_q;
            // ready in the final wait cycle still counts as success
            if (mem_ready) begin
               state_d = op_q ? S_DONE : S_CAPTURE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CAPTURE: begin
            MDRin   = 1'b1;
            read    = 1'b1;
            state_d = S_DRIVE;
         end
         S_DRIVE: begin
            MDRout  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            done    = 1'b1;
            error   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
